// File: rtl/wb_buffer.sv
// Writeback buffer: in-order FIFO of (rd, data) results draining into the regfile write port.
// Latency: push on edge N is presented as a regfile write during cycle N->N+1 when empty and unstalled.
// Backpressure: o_wb_ready drops at count == DEPTH (same-cycle pop space not reused); i_wb_stall holds the head.
// Optional feature macro: WB_BYPASS_EN adds youngest-match rs1/rs2 bypass lookup ports.
module wb_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_wb_valid,
  output logic                       o_wb_ready,
  input  logic [4:0]                 i_wb_addr,
  input  logic [31:0]                i_wb_data,
  input  logic                       i_wb_stall,
  output logic [4:0]                 o_rd_addr,
  output logic [31:0]                o_rd_data,
  output logic                       o_rd_wren,
  output logic [31:0]                o_pending,
`ifdef WB_BYPASS_EN
  input  logic [4:0]                 i_rs1_addr,
  input  logic [4:0]                 i_rs2_addr,
  output logic                       o_rs1_hit,
  output logic                       o_rs2_hit,
  output logic [31:0]                o_rs1_data,
  output logic [31:0]                o_rs2_data,
`endif
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [4:0]    addr_mem_q [DEPTH];
  logic [31:0]   data_mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          nonempty;
  logic          push;
  logic          store;
  logic          pop;
  logic [PW-1:0] offs;

  // Handshake, pointer/count next state and head presentation.
  always_comb begin
    nonempty   = (count_q != '0);
    o_wb_ready = (count_q < FULL_CNT) && i_reset;
    push       = i_wb_valid && o_wb_ready;
    // Writes to x0 are acknowledged but dropped.
    store      = push && (i_wb_addr != 5'd0);
    // Reset gates the write so discarded entries never reach the regfile.
    pop        = nonempty && !i_wb_stall && i_reset;
    wr_ptr_d   = store ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d    = count_q;
    if (store && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!store && pop) begin
      count_d = count_q - CW'(1);
    end
    o_rd_wren = pop;
    o_rd_addr = (nonempty && i_reset) ? addr_mem_q[rd_ptr_q] : 5'd0;
    o_rd_data = (nonempty && i_reset) ? data_mem_q[rd_ptr_q] : 32'd0;
    o_count   = count_q;
  end

  // Pending mask: a slot is held when its distance from the read pointer is below count.
  always_comb begin
    o_pending = '0;
    offs      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs = PW'(i) - rd_ptr_q;
      if ({1'b0, offs} < count_q) begin
        o_pending[addr_mem_q[i]] = 1'b1;
      end
    end
    o_pending[0] = 1'b0;
  end

`ifdef WB_BYPASS_EN
  logic [PW-1:0] idx;

  // Bypass lookup: scan oldest to youngest so the youngest match wins.
  always_comb begin
    o_rs1_hit  = 1'b0;
    o_rs2_hit  = 1'b0;
    o_rs1_data = '0;
    o_rs2_data = '0;
    idx        = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PW'(k);
      if (CW'(k) < count_q) begin
        if ((i_rs1_addr != 5'd0) && (addr_mem_q[idx] == i_rs1_addr)) begin
          o_rs1_hit  = 1'b1;
          o_rs1_data = data_mem_q[idx];
        end
        if ((i_rs2_addr != 5'd0) && (addr_mem_q[idx] == i_rs2_addr)) begin
          o_rs2_hit  = 1'b1;
          o_rs2_data = data_mem_q[idx];
        end
      end
    end
  end
`endif

  // Control state with synchronous active-low reset; clearing count discards all held entries.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful while counted as held, so no reset.
  always_ff @(posedge i_clk) begin
    if (store) begin
      addr_mem_q[wr_ptr_q] <= i_wb_addr;
      data_mem_q[wr_ptr_q] <= i_wb_data;
    end
  end

endmodule

// File: tb/tb_wb_buffer.sv
// Bench for wb_buffer: directed scenarios plus randomized traffic against a queue model.
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
// Reset, stall, x0 filtering, full backpressure and (with WB_BYPASS_EN) bypass are covered.
module tb_wb_buffer;

  localparam int DEPTH = 4;

  logic        i_clk;
  logic        i_reset;
  logic        i_wb_valid;
  logic        o_wb_ready;
  logic [4:0]  i_wb_addr;
  logic [31:0] i_wb_data;
  logic        i_wb_stall;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data;
  logic        o_rd_wren;
  logic [31:0] o_pending;
  logic [2:0]  o_count;
  logic [4:0]  i_rs1_addr;
  logic [4:0]  i_rs2_addr;
  logic        o_rs1_hit;
  logic        o_rs2_hit;
  logic [31:0] o_rs1_data;
  logic [31:0] o_rs2_data;

  int errs;
  int checks;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t mq[$];

  wb_buffer #(.DEPTH(DEPTH)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_wb_valid (i_wb_valid),
    .o_wb_ready (o_wb_ready),
    .i_wb_addr  (i_wb_addr),
    .i_wb_data  (i_wb_data),
    .i_wb_stall (i_wb_stall),
    .o_rd_addr  (o_rd_addr),
    .o_rd_data  (o_rd_data),
    .o_rd_wren  (o_rd_wren),
    .o_pending  (o_pending),
`ifdef WB_BYPASS_EN
    .i_rs1_addr (i_rs1_addr),
    .i_rs2_addr (i_rs2_addr),
    .o_rs1_hit  (o_rs1_hit),
    .o_rs2_hit  (o_rs2_hit),
    .o_rs1_data (o_rs1_data),
    .o_rs2_data (o_rs2_data),
`endif
    .o_count    (o_count)
  );

`ifndef WB_BYPASS_EN
  assign o_rs1_hit  = 1'b0;
  assign o_rs2_hit  = 1'b0;
  assign o_rs1_data = 32'd0;
  assign o_rs2_data = 32'd0;
`endif

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference model: a plain FIFO queue updated from the inputs seen at each rising edge.
  task automatic tick();
    int   sz;
    ent_t e;
    @(posedge i_clk);
    sz = mq.size();
    if (!i_reset) begin
      mq.delete();
    end else begin
      if (sz != 0 && !i_wb_stall) void'(mq.pop_front());
      if (i_wb_valid && sz < DEPTH && i_wb_addr != 5'd0) begin
        e.a = i_wb_addr;
        e.d = i_wb_data;
        mq.push_back(e);
      end
    end
    @(negedge i_clk);
  endtask

  function automatic logic [31:0] m_pending();
    logic [31:0] p;
    p = '0;
    foreach (mq[i]) p[mq[i].a] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  function automatic logic m_wren();
    return i_reset && mq.size() != 0 && !i_wb_stall;
  endfunction

  function automatic logic m_ready();
    return i_reset && mq.size() < DEPTH;
  endfunction

  function automatic logic [36:0] m_head();
    if (i_reset && mq.size() != 0) return mq[0];
    return '0;
  endfunction

  // Returns {hit, data} for the youngest held entry matching rs.
  function automatic logic [32:0] m_bypass(input logic [4:0] rs);
    logic [32:0] r;
    r = '0;
    if (rs != 5'd0) begin
      foreach (mq[i]) if (mq[i].a == rs) r = {1'b1, mq[i].d};
    end
    return r;
  endfunction

  task automatic test_reset();
    i_reset = 1'b0;
    #1;
    checks++;
    if (o_wb_ready !== 1'b0) begin errs++; $display("FAIL reset_ready_low got=%0b exp=0", o_wb_ready); end
    checks++;
    if (o_rd_wren !== 1'b0) begin errs++; $display("FAIL reset_wren_low got=%0b exp=0", o_rd_wren); end
    tick();
    tick();
    i_reset = 1'b1;
    #1;
    checks++;
    if (o_count !== 3'd0) begin errs++; $display("FAIL reset_count got=%0d exp=0", o_count); end
    checks++;
    if (o_rd_wren !== 1'b0) begin errs++; $display("FAIL reset_wren got=%0b exp=0", o_rd_wren); end
    checks++;
    if (o_pending !== 32'd0) begin errs++; $display("FAIL reset_pending got=%h exp=0", o_pending); end
    checks++;
    if (o_wb_ready !== 1'b1) begin errs++; $display("FAIL reset_ready got=%0b exp=1", o_wb_ready); end
    checks++;
    if (o_rd_addr !== 5'd0 || o_rd_data !== 32'd0) begin
      errs++; $display("FAIL reset_head got=%0d/%h exp=0/0", o_rd_addr, o_rd_data);
    end
  endtask

  task automatic test_single_push();
    i_wb_valid = 1'b1; i_wb_addr = 5'd5; i_wb_data = 32'hDEADBEEF;
    tick();
    i_wb_valid = 1'b0; i_wb_addr = 5'd0; i_wb_data = 32'd0;
    #1;
    checks++;
    if (o_rd_wren !== 1'b1 || o_rd_addr !== 5'd5 || o_rd_data !== 32'hDEADBEEF) begin
      errs++; $display("FAIL single_head got=%0b/%0d/%h exp=1/5/deadbeef", o_rd_wren, o_rd_addr, o_rd_data);
    end
    checks++;
    if (o_pending !== 32'h0000_0020 || o_count !== 3'd1) begin
      errs++; $display("FAIL single_pending got=%h/%0d exp=00000020/1", o_pending, o_count);
    end
    tick();
    #1;
    checks++;
    if (o_count !== 3'd0 || o_pending[5] !== 1'b0 || o_rd_wren !== 1'b0) begin
      errs++; $display("FAIL single_drained got=%0d/%0b/%0b exp=0/0/0", o_count, o_pending[5], o_rd_wren);
    end
  endtask

  task automatic test_stall_full();
    logic [4:0]  ta [4];
    logic [31:0] td [4];
    ta = '{5'd10, 5'd1, 5'd31, 5'd15};
    td = '{32'h12345678, 32'hFFFFFFFF, 32'hCAFEBABE, 32'h55AA55AA};
    i_wb_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_wb_valid = 1'b1; i_wb_addr = ta[i]; i_wb_data = td[i];
      tick();
    end
    i_wb_addr = 5'd3; i_wb_data = 32'h33333333;
    #1;
    checks++;
    if (o_count !== 3'd4 || o_wb_ready !== 1'b0) begin
      errs++; $display("FAIL full_state got=%0d/%0b exp=4/0", o_count, o_wb_ready);
    end
    checks++;
    if (o_rd_wren !== 1'b0 || o_rd_addr !== 5'd10) begin
      errs++; $display("FAIL full_stalled_head got=%0b/%0d exp=0/10", o_rd_wren, o_rd_addr);
    end
    checks++;
    if (o_pending !== 32'h8000_8402) begin
      errs++; $display("FAIL full_pending got=%h exp=80008402", o_pending);
    end
    tick();
    i_wb_valid = 1'b0;
    #1;
    checks++;
    if (o_count !== 3'd4) begin errs++; $display("FAIL full_fifth_rejected got=%0d exp=4", o_count); end
    i_wb_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (o_rd_wren !== 1'b1 || o_rd_addr !== ta[i] || o_rd_data !== td[i]) begin
        errs++; $display("FAIL drain_%0d got=%0b/%0d/%h exp=1/%0d/%h", i, o_rd_wren, o_rd_addr, o_rd_data, ta[i], td[i]);
      end
      tick();
    end
    #1;
    checks++;
    if (o_count !== 3'd0 || o_rd_wren !== 1'b0) begin
      errs++; $display("FAIL drain_empty got=%0d/%0b exp=0/0", o_count, o_rd_wren);
    end
  endtask

  task automatic test_x0();
    i_wb_valid = 1'b1; i_wb_addr = 5'd0; i_wb_data = 32'hFFFFFFFF;
    #1;
    checks++;
    if (o_wb_ready !== 1'b1) begin errs++; $display("FAIL x0_ready got=%0b exp=1", o_wb_ready); end
    tick();
    i_wb_valid = 1'b0;
    #1;
    checks++;
    if (o_count !== 3'd0 || o_rd_wren !== 1'b0 || o_pending !== 32'd0) begin
      errs++; $display("FAIL x0_dropped got=%0d/%0b/%h exp=0/0/0", o_count, o_rd_wren, o_pending);
    end
  endtask

`ifdef WB_BYPASS_EN
  task automatic test_bypass();
    i_wb_stall = 1'b1;
    i_wb_valid = 1'b1; i_wb_addr = 5'd5; i_wb_data = 32'h0A0A0A0A;
    tick();
    i_wb_data = 32'h11111111;
    tick();
    i_wb_valid = 1'b0;
    i_rs1_addr = 5'd5; i_rs2_addr = 5'd0;
    #1;
    checks++;
    if (o_rs1_hit !== 1'b1 || o_rs1_data !== 32'h11111111) begin
      errs++; $display("FAIL bypass_youngest got=%0b/%h exp=1/11111111", o_rs1_hit, o_rs1_data);
    end
    checks++;
    if (o_rs2_hit !== 1'b0 || o_rs2_data !== 32'd0) begin
      errs++; $display("FAIL bypass_x0 got=%0b/%h exp=0/0", o_rs2_hit, o_rs2_data);
    end
    i_wb_stall = 1'b0;
    tick();
    #1;
    checks++;
    if (o_rs1_hit !== 1'b1 || o_rs1_data !== 32'h11111111) begin
      errs++; $display("FAIL bypass_after_pop got=%0b/%h exp=1/11111111", o_rs1_hit, o_rs1_data);
    end
    tick();
    #1;
    checks++;
    if (o_rs1_hit !== 1'b0 || o_rs1_data !== 32'd0) begin
      errs++; $display("FAIL bypass_empty got=%0b/%h exp=0/0", o_rs1_hit, o_rs1_data);
    end
    i_rs1_addr = 5'd0;
  endtask
`endif

  task automatic test_reset_mid();
    i_wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_wb_valid = 1'b1; i_wb_addr = 5'(7 + i); i_wb_data = $urandom;
      tick();
    end
    i_wb_valid = 1'b0;
    i_wb_stall = 1'b0;
    i_reset = 1'b0;
    #1;
    checks++;
    if (o_rd_wren !== 1'b0 || o_count !== 3'd3) begin
      errs++; $display("FAIL midreset_nowrite got=%0b/%0d exp=0/3", o_rd_wren, o_count);
    end
    tick();
    i_reset = 1'b1;
    #1;
    checks++;
    if (o_count !== 3'd0 || o_pending !== 32'd0 || o_rd_wren !== 1'b0) begin
      errs++; $display("FAIL midreset_cleared got=%0d/%h/%0b exp=0/0/0", o_count, o_pending, o_rd_wren);
    end
  endtask

  task automatic test_random();
    logic [32:0] b1;
    logic [32:0] b2;
    logic [36:0] hd;
    for (int n = 0; n < 800; n++) begin
      i_reset    = ($urandom_range(99) != 0);
      i_wb_valid = 1'($urandom_range(1));
      i_wb_addr  = ($urandom_range(3) == 0) ? 5'($urandom) : 5'($urandom_range(6));
      i_wb_data  = $urandom;
      i_wb_stall = ($urandom_range(3) == 0);
      i_rs1_addr = 5'($urandom_range(7));
      i_rs2_addr = 5'($urandom_range(7));
      #1;
      hd = m_head();
      checks++;
      if (o_wb_ready !== m_ready()) begin errs++; $display("FAIL rnd_ready n=%0d got=%0b exp=%0b", n, o_wb_ready, m_ready()); end
      checks++;
      if (o_rd_wren !== m_wren()) begin errs++; $display("FAIL rnd_wren n=%0d got=%0b exp=%0b", n, o_rd_wren, m_wren()); end
      checks++;
      if ({o_rd_addr, o_rd_data} !== hd) begin
        errs++; $display("FAIL rnd_head n=%0d got=%0d/%h exp=%0d/%h", n, o_rd_addr, o_rd_data, hd[36:32], hd[31:0]);
      end
      checks++;
      if (o_count !== 3'(mq.size())) begin errs++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, o_count, mq.size()); end
      checks++;
      if (o_pending !== m_pending()) begin errs++; $display("FAIL rnd_pending n=%0d got=%h exp=%h", n, o_pending, m_pending()); end
`ifdef WB_BYPASS_EN
      b1 = m_bypass(i_rs1_addr);
      b2 = m_bypass(i_rs2_addr);
      checks++;
      if ({o_rs1_hit, o_rs1_data} !== b1 || {o_rs2_hit, o_rs2_data} !== b2) begin
        errs++; $display("FAIL rnd_bypass n=%0d got=%0b/%h %0b/%h exp=%0b/%h %0b/%h", n,
                         o_rs1_hit, o_rs1_data, o_rs2_hit, o_rs2_data, b1[32], b1[31:0], b2[32], b2[31:0]);
      end
`else
      b1 = '0;
      b2 = '0;
`endif
      tick();
    end
    i_wb_valid = 1'b0;
    i_rs1_addr = 5'd0;
    i_rs2_addr = 5'd0;
  endtask

  initial begin
    errs       = 0;
    checks     = 0;
    i_reset    = 1'b0;
    i_wb_valid = 1'b0;
    i_wb_addr  = 5'd0;
    i_wb_data  = 32'd0;
    i_wb_stall = 1'b0;
    i_rs1_addr = 5'd0;
    i_rs2_addr = 5'd0;
    @(negedge i_clk);
    test_reset();
    test_single_push();
    test_stall_full();
    test_x0();
`ifdef WB_BYPASS_EN
    test_bypass();
`endif
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/wb_buffer.md
# wb_buffer

Writeback buffer sitting between the execute/memory result producers and the regfile write port (`i_rd_addr`/`i_rd_data`/`i_rd_wren`). It accepts (rd, data) results over a valid/ready handshake, holds them in an in-order FIFO, and drains one entry per cycle into the regfile unless stalled. It also publishes a pending-write mask and, optionally, a youngest-match bypass so decode never reads a stale register.

## Interface
- `DEPTH`, 4, number of FIFO entries; power of two, ≥ 2
- `i_clk`  in  1  clock; all state updates on the rising edge
- `i_reset`  in  1  synchronous, active-low reset
- `i_wb_valid`  in  1  producer has a result
- `o_wb_ready`  out  1  buffer can accept this cycle
- `i_wb_addr`  in  5  destination register
- `i_wb_data`  in  32  result value
- `i_wb_stall`  in  1  regfile write port unavailable; no pop this cycle
- `o_rd_addr`  out  5  to regfile `i_rd_addr`
- `o_rd_data`  out  32  to regfile `i_rd_data`
- `o_rd_wren`  out  1  to regfile `i_rd_wren`
- `o_pending`  out  32  bit r set while any held entry targets register r; bit 0 always 0
- `o_count`  out  $clog2(DEPTH)+1  entries held
- `i_rs1_addr`, `i_rs2_addr`  in  5  bypass lookup addresses (only with `WB_BYPASS_EN`)
- `o_rs1_hit`, `o_rs2_hit`  out  1  lookup matched a held entry (only with `WB_BYPASS_EN`)
- `o_rs1_data`, `o_rs2_data`  out  32  youngest matching entry data (only with `WB_BYPASS_EN`)

## Operation
- Storage: DEPTH × {addr[4:0], data[31:0]}, write pointer, read pointer, count.
- Push: accepted on a rising edge with `i_wb_valid && o_wb_ready`. `o_wb_ready = (count < DEPTH) && i_reset`; it does not use same-cycle pop space.
- x0 filtering: a push with `i_wb_addr == 0` is accepted (ready honoured) but not stored; count unchanged.
- Head output, combinational from head entry: `o_rd_wren = (count != 0) && !i_wb_stall`. `o_rd_addr`/`o_rd_data` show the head entry when count ≠ 0; otherwise 0.
- Pop: on every edge where `o_rd_wren` is 1, the read pointer advances. Regfile performs the write on the same edge.
- Simultaneous push and pop: both occur; count unchanged; order preserved.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; full/empty come from count only.
- `o_pending`: OR over held entries of onehot(addr). A register written twice stays pending until both entries drain.
- Reset (low on an edge): pointers, count and all entry valid state clear. Held entries are discarded and never written to the regfile, including mid-drain. Data RAM contents need not clear.

## Timing
- Reset values: `o_wb_ready` 0 while `i_reset` low, 1 on the first cycle after. `o_rd_wren` 0, `o_rd_addr` 0, `o_rd_data` 0, `o_pending` 0, `o_count` 0. Bypass hits 0, bypass data 0.
- Latency: a push on edge N into an empty, unstalled buffer gives `o_rd_wren` = 1 during cycle N→N+1. The regfile holds the value after edge N+1. A regfile read returns it in the following cycle.
- Throughput: one push and one pop per cycle.
- Stall: while `i_wb_stall` is 1, entries hold and pushes continue until count = DEPTH.

## Configuration
- `WB_BYPASS_EN` defined: the bypass ports exist.
  - `o_rsN_hit` = 1 if any held entry (head included) has `addr == i_rsN_addr` and `i_rsN_addr != 0`.
  - `o_rsN_data` is the youngest such entry's data, else 0. Purely combinational, same cycle.
- Not defined: the bypass ports and logic are absent. Consumers must stall on `o_pending`.

## Test plan
- Reset then idle: hold `i_reset` = 0 for 2 cycles, then release → `o_count` = 0, `o_rd_wren` = 0, `o_pending` = 0, `o_wb_ready` = 1.
- Single push: addr 5, data DEADBEEF, no stall → next cycle `o_rd_wren` = 1, addr 5, data DEADBEEF; one cycle later `o_count` = 0 and `o_pending[5]` = 0.
- Stall to full: `i_wb_stall` = 1, push 10/12345678, 1/FFFFFFFF, 31/CAFEBABE, 15/55AA55AA.
  - Expect `o_count` = 4 and `o_wb_ready` = 0; a 5th push is not accepted.
  - Release stall → four writes drain in push order on consecutive cycles.
- x0 filter: push 0/FFFFFFFF → accepted, `o_count` stays 0, no `o_rd_wren`, `o_pending` = 0.
- Bypass (`WB_BYPASS_EN`), stalled: push 5/0A0A0A0A then 5/11111111, set `i_rs1_addr` = 5 and `i_rs2_addr` = 0.
  - Expect `o_rs1_hit` = 1 with `o_rs1_data` = 11111111, and `o_rs2_hit` = 0.
- Reset mid-operation: with 3 held entries, pull `i_reset` low for one edge → `o_count` = 0, no regfile write of the discarded entries, `o_pending` = 0.
